// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction-fetch front end: reset vector,
// sequential PC increment and the fetch sequencer state encoding.
package cpu_pkg;

    localparam logic [31:0] RESET_PC = 32'h1c00_0000;
    localparam logic [31:0] PC_STEP  = 32'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl.sv
// IF-stage fetch sequencer. Owns the fetch PC, issues one request at a time
// on the SRAM-like instruction port, buffers the returned word and hands it
// to ID over the valid/allow_in handshake. Branch redirects replace the
// fetch PC and cancel whatever is in flight or buffered.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | just out of reset, no request yet
// REQ   | request presented at fetch_pc, waiting for addr_ok
// WAIT  | request accepted, waiting for data_ok (discard drops the word)
// HOLD  | instruction buffered in fs_pc/fs_inst, waiting to move to ID
module fetch_ctrl
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC,
    parameter logic [31:0] PC_STEP  = cpu_pkg::PC_STEP
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        stall,
    input  logic        ds_allow_in,
    output logic        inst_sram_req,
    output logic [31:0] inst_sram_addr,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata,
    output logic        fs_valid,
    output logic        fs_to_ds_valid,
    output logic [31:0] fs_pc,
    output logic [31:0] fs_inst
);

    fetch_state_t state, state_nxt;
    logic [31:0]  fetch_pc, fetch_pc_nxt;
    logic         discard, discard_nxt;
    logic         fs_valid_nxt;
    logic [31:0]  fs_pc_nxt;
    logic [31:0]  fs_inst_nxt;

    // A branch in the same cycle kills the hand-off: the buffered word is
    // on the wrong path.
    assign fs_to_ds_valid = fs_valid & ~stall & ds_allow_in & ~br_taken;
    assign inst_sram_req  = (state == REQ);
    assign inst_sram_addr = fetch_pc;

    // Next-state, fetch PC, discard flag and instruction buffer.
    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        discard_nxt  = discard;
        fs_valid_nxt = fs_valid;
        fs_pc_nxt    = fs_pc;
        fs_inst_nxt  = fs_inst;
        case (state)
            IDLE: begin
                state_nxt = REQ;
                if (br_taken) begin
                    fetch_pc_nxt = br_target;
                end
            end
            REQ: begin
                if (inst_sram_addr_ok) begin
                    state_nxt = WAIT;
                    // The accepted address is the old path; its data must die.
                    if (br_taken) begin
                        discard_nxt = 1'b1;
                    end
                end
                if (br_taken) begin
                    fetch_pc_nxt = br_target;
                end
            end
            WAIT: begin
                if (inst_sram_data_ok) begin
                    if (discard || br_taken) begin
                        discard_nxt = 1'b0;
                        state_nxt   = REQ;
                        if (br_taken) begin
                            fetch_pc_nxt = br_target;
                        end
                    end else begin
                        fs_inst_nxt  = inst_sram_rdata;
                        fs_pc_nxt    = fetch_pc;
                        fs_valid_nxt = 1'b1;
                        state_nxt    = HOLD;
                    end
                end else if (br_taken) begin
                    discard_nxt  = 1'b1;
                    fetch_pc_nxt = br_target;
                end
            end
            HOLD: begin
                if (br_taken) begin
                    fs_valid_nxt = 1'b0;
                    fetch_pc_nxt = br_target;
                    state_nxt    = REQ;
                end else if (fs_to_ds_valid) begin
                    fs_valid_nxt = 1'b0;
                    fetch_pc_nxt = fs_pc + PC_STEP;
                    state_nxt    = REQ;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, PC and buffer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            discard  <= 1'b0;
            fs_valid <= 1'b0;
            fs_pc    <= 32'd0;
            fs_inst  <= 32'd0;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            discard  <= discard_nxt;
            fs_valid <= fs_valid_nxt;
            fs_pc    <= fs_pc_nxt;
            fs_inst  <= fs_inst_nxt;
        end
    end

endmodule
